ysyx_23060077_mdu_ctrl: RTL and testbench

Iterative RV32M multiply/divide sequencer that sits beside the EXU ALU. It accepts one operation when the decoder flags alu_mul or alu_div, using funct3 to select the variant. It runs a radix-2 shift-add multiply or a restoring divide over 32 cycles and returns the result on a valid/ready handshake. The pipeline stalls on in_ready or out_valid; flush cancels in-flight work on redirect or trap.

---
 rtl/ysyx_23060077_mdu_ctrl_if.sv | 27 ++
 rtl/ysyx_23060077_mdu_ctrl.sv | 152 +++++++++++++++
 tb/tb_ysyx_23060077_mdu_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060077_mdu_ctrl_if.sv
// Request/response bundle between the EXU and the iterative RV32M multiply/divide unit.
interface ysyx_23060077_mdu_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  alu_mul;
  logic                  alu_div;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] src1;
  logic [DATA_WIDTH-1:0] src2;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;
  logic                  busy;

  modport master (
    output in_valid, alu_mul, alu_div, funct3, src1, src2, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, alu_mul, alu_div, funct3, src1, src2, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/ysyx_23060077_mdu_ctrl.sv
// Iterative RV32M sequencer: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign fix-up applied on the last step.
module ysyx_23060077_mdu_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
) (
  input logic                     clk,
  input logic                     rst_n,
  ysyx_23060077_mdu_ctrl_if.slave bus
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, DONE = 2'b10} state_t;

  state_t               state_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic [2*W-1:0]       prod_r;
  logic [W-1:0]         opb_r, quo_r, rem_r, result_r;
  logic                 is_div_r, sel_r, neg_a_r, neg_b_r, dz_r;
  logic                 in_ready_r, out_valid_r, busy_r;

  logic                 accept_s, take_div_s, sgn1_s, sgn2_s, neg1_s, neg2_s;
  logic [W-1:0]         mag1_s, mag2_s;
  logic [W:0]           sum_s, shift_s, diff_s;
  logic [2*W-1:0]       prod_nxt_s, prodn_s;
  logic [W-1:0]         rem_nxt_s, quo_nxt_s, final_s;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.busy      = busy_r;

  // Decode the offered operation into operand magnitudes and sign flags.
  always_comb begin
    take_div_s = ~bus.alu_mul & bus.alu_div;
    accept_s   = bus.in_valid & in_ready_r & (bus.alu_mul | bus.alu_div) & ~bus.flush;
    if (take_div_s) begin
      sgn1_s = ~bus.funct3[0];
      sgn2_s = ~bus.funct3[0];
    end else begin
      sgn1_s = (bus.funct3[1:0] != 2'b11);
      sgn2_s = ~bus.funct3[1];
    end
    neg1_s = sgn1_s & bus.src1[W-1];
    neg2_s = sgn2_s & bus.src2[W-1];
    mag1_s = neg1_s ? -bus.src1 : bus.src1;
    mag2_s = neg2_s ? -bus.src2 : bus.src2;
  end

  // One multiply step and one divide step, plus the signed result of the final step.
  always_comb begin
    sum_s      = {1'b0, prod_r[2*W-1:W]} + (prod_r[0] ? {1'b0, opb_r} : {(W+1){1'b0}});
    prod_nxt_s = {sum_s, prod_r[W-1:1]};
    shift_s    = {rem_r, quo_r[W-1]};
    diff_s     = shift_s - {1'b0, opb_r};
    if (diff_s[W]) begin
      rem_nxt_s = shift_s[W-1:0];
      quo_nxt_s = {quo_r[W-2:0], 1'b0};
    end else begin
      rem_nxt_s = diff_s[W-1:0];
      quo_nxt_s = {quo_r[W-2:0], 1'b1};
    end
    prodn_s = neg_a_r ? -prod_nxt_s : prod_nxt_s;
    if (dz_r) begin
      // quo_r still holds |src1|; re-signing it restores src1 unchanged.
      final_s = sel_r ? (neg_b_r ? -quo_r : quo_r) : {W{1'b1}};
    end else if (is_div_r) begin
      if (sel_r) begin
        final_s = neg_b_r ? -rem_nxt_s : rem_nxt_s;
      end else begin
        final_s = neg_a_r ? -quo_nxt_s : quo_nxt_s;
      end
    end else begin
      final_s = sel_r ? prodn_s[2*W-1:W] : prodn_s[W-1:0];
    end
  end

  // Sequencer FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_WIDTH{1'b0}};
      prod_r      <= {(2*W){1'b0}};
      opb_r       <= {W{1'b0}};
      quo_r       <= {W{1'b0}};
      rem_r       <= {W{1'b0}};
      result_r    <= {W{1'b0}};
      is_div_r    <= 1'b0;
      sel_r       <= 1'b0;
      neg_a_r     <= 1'b0;
      neg_b_r     <= 1'b0;
      dz_r        <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else if (bus.flush) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_WIDTH{1'b0}};
      result_r    <= {W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r    <= CALC;
            cnt_r      <= {CNT_WIDTH{1'b0}};
            is_div_r   <= take_div_s;
            sel_r      <= take_div_s ? bus.funct3[1] : (bus.funct3[1:0] != 2'b00);
            neg_a_r    <= neg1_s ^ neg2_s;
            neg_b_r    <= neg1_s;
            dz_r       <= take_div_s & (bus.src2 == {W{1'b0}});
            prod_r     <= {{W{1'b0}}, mag2_s};
            opb_r      <= take_div_s ? mag2_s : mag1_s;
            quo_r      <= mag1_s;
            rem_r      <= {W{1'b0}};
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        CALC: begin
          prod_r <= prod_nxt_s;
          quo_r  <= quo_nxt_s;
          rem_r  <= rem_nxt_s;
          cnt_r  <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          if (dz_r || (cnt_r == CNT_WIDTH'(W - 1))) begin
            state_r     <= DONE;
            result_r    <= final_s;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_r     <= IDLE;
            result_r    <= {W{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          result_r    <= {W{1'b0}};
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_23060077_mdu_ctrl.sv
// Directed bench for the RV32M sequencer: results, latency, hold, flush and reset behaviour.
module tb_ysyx_23060077_mdu_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ysyx_23060077_mdu_ctrl_if #(.DATA_WIDTH(32)) bus ();

  ysyx_23060077_mdu_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  // Called at posedge+1; offers one op, measures latency, checks result and (if rdy) the handshake.
  task automatic do_op(input logic m, input logic d, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat,
                       input logic rdy, input string tag);
    int n;
    bus.in_valid  = 1'b1;
    bus.alu_mul   = m;
    bus.alu_div   = d;
    bus.funct3    = f3;
    bus.src1      = a;
    bus.src2      = b;
    bus.out_ready = rdy;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.alu_mul  = 1'b0;
    bus.alu_div  = 1'b0;
    bus.src1     = $urandom;
    bus.src2     = $urandom;
    chk1({tag, "_busy"}, bus.busy, 1'b1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.out_valid !== 1'b1 && n < 40);
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_res"}, bus.result, exp_res);
    chk1({tag, "_inrdy_done"}, bus.in_ready, 1'b0);
    if (rdy) begin
      @(posedge clk); #1;
      chk1({tag, "_ov_after"}, bus.out_valid, 1'b0);
      chk1({tag, "_inrdy_after"}, bus.in_ready, 1'b1);
      chk({tag, "_res_after"}, bus.result, 32'h0000_0000);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin : stim
    int seen;
    checks = 0;
    errors = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alu_mul   = 1'b0;
    bus.alu_div   = 1'b0;
    bus.funct3    = 3'b000;
    bus.src1      = 32'h0;
    bus.src2      = 32'h0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk1("rst_inrdy", bus.in_ready, 1'b1);
    chk1("rst_ov", bus.out_valid, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk("rst_res", bus.result, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(1'b1, 1'b0, 3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 32, 1'b1, "mul");
    do_op(1'b1, 1'b0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32, 1'b1, "mulhu");
    do_op(1'b1, 1'b0, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32, 1'b1, "mulh");
    do_op(1'b1, 1'b0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 1'b1, "mulhsu");
    do_op(1'b0, 1'b1, 3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32, 1'b1, "div");
    do_op(1'b0, 1'b1, 3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32, 1'b1, "rem");
    do_op(1'b0, 1'b1, 3'b101, 32'd100,      32'd7,        32'd14,        32, 1'b1, "divu");
    do_op(1'b0, 1'b1, 3'b111, 32'd100,      32'd7,        32'd2,         32, 1'b1, "remu");
    do_op(1'b0, 1'b1, 3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 1,  1'b1, "divu_z");
    do_op(1'b0, 1'b1, 3'b110, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 1,  1'b1, "rem_z");
    do_op(1'b0, 1'b1, 3'b100, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFF, 1,  1'b1, "div_z");
    do_op(1'b0, 1'b1, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32, 1'b1, "div_ovf");
    do_op(1'b0, 1'b1, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32, 1'b1, "rem_ovf");
    // Both flags set: multiply wins (MULHU variant).
    do_op(1'b1, 1'b1, 3'b011, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 32, 1'b1, "both");

    // Consumer stalls for 5 cycles while a new op is offered.
    do_op(1'b1, 1'b0, 3'b000, 32'd3, 32'd5, 32'd15, 32, 1'b0, "hold");
    bus.in_valid = 1'b1;
    bus.alu_mul  = 1'b1;
    bus.src1     = 32'd9;
    bus.src2     = 32'd9;
    repeat (5) begin
      @(posedge clk); #1;
      chk1("hold_ov", bus.out_valid, 1'b1);
      chk("hold_res", bus.result, 32'd15);
      chk1("hold_inrdy", bus.in_ready, 1'b0);
    end
    bus.in_valid  = 1'b0;
    bus.alu_mul   = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk1("hold_ov_rel", bus.out_valid, 1'b0);
    chk1("hold_busy_rel", bus.busy, 1'b0);
    chk1("hold_inrdy_rel", bus.in_ready, 1'b1);

    // Flush sampled on iteration 10 cancels the op.
    bus.in_valid = 1'b1;
    bus.alu_mul  = 1'b1;
    bus.funct3   = 3'b000;
    bus.src1     = 32'd9;
    bus.src2     = 32'd9;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.alu_mul  = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk1("pre_flush_busy", bus.busy, 1'b1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk1("flush_busy", bus.busy, 1'b0);
    chk1("flush_inrdy", bus.in_ready, 1'b1);
    chk1("flush_ov", bus.out_valid, 1'b0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen = 1;
    end
    chk("flush_no_ov", 32'(seen), 32'd0);
    do_op(1'b1, 1'b0, 3'b000, 32'd3, 32'd4, 32'd12, 32, 1'b1, "post_flush");

    // Asynchronous reset in the middle of a calculation.
    bus.in_valid = 1'b1;
    bus.alu_mul  = 1'b1;
    bus.src1     = 32'd11;
    bus.src2     = 32'd13;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.alu_mul  = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk1("mrst_inrdy", bus.in_ready, 1'b1);
    chk1("mrst_ov", bus.out_valid, 1'b0);
    chk1("mrst_busy", bus.busy, 1'b0);
    chk("mrst_res", bus.result, 32'h0);
    #5;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(1'b0, 1'b1, 3'b101, 32'd100, 32'd7, 32'd14, 32, 1'b1, "post_rst");

    // Valid without a multiply/divide class is ignored.
    bus.in_valid = 1'b1;
    bus.funct3   = 3'b000;
    @(posedge clk); #1;
    chk1("noclass_busy", bus.busy, 1'b0);
    chk1("noclass_inrdy", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    chk1("noclass_busy2", bus.busy, 1'b0);
    bus.in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
